// File: rtl/bcd_time_counter.sv
// 24-hour hh:mm:ss time-of-day counter kept in BCD, one 4-bit digit per output.
// An internal prescaler divides the clock down to the second-advance rate.
// Single-cycle set pulses add one minute or one hour.
module bcd_time_counter #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] hr_tens,
    output logic       tick
);

    localparam int unsigned Div      = CLK_HZ / TICK_HZ;
    // Div must be at least 2, so the width never collapses to zero.
    localparam int unsigned PreWidth = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [PreWidth-1:0] PreMax = PreWidth'(Div - 1);

    logic [PreWidth-1:0] presc_q, presc_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] hr_ones_q, hr_ones_d;
    logic [3:0] hr_tens_q, hr_tens_d;
    logic       tick_q, tick_d;

    logic advance;   // prescaler at terminal count while running
    logic time_adv;  // advance that survives a same-cycle inc_min
    logic sec_wrap;  // seconds at 59
    logic min_wrap;  // minutes at 59
    logic min_step;  // minutes take +1 this cycle
    logic hr_step;   // hours take +1 this cycle

    // Decode the terminal count and the ripple-carry enables.
    always_comb begin
        advance  = run && (presc_q == PreMax);
        // inc_min clears seconds and the prescaler, so a coincident advance is dropped.
        time_adv = advance && !inc_min;
        sec_wrap = (sec_ones_q == 4'd9) && (sec_tens_q == 4'd5);
        min_wrap = (min_ones_q == 4'd9) && (min_tens_q == 4'd5);
        // Set pulses never ripple: inc_min alone leaves hours untouched.
        min_step = inc_min || (time_adv && sec_wrap);
        // A carry from the seconds chain and inc_hour merge into a single +1.
        hr_step  = inc_hour || (time_adv && sec_wrap && min_wrap);
    end

    // Prescaler next state: restart on inc_min, count while running, else hold.
    always_comb begin
        presc_d = presc_q;
        if (inc_min) begin
            presc_d = '0;
        end else if (run) begin
            if (presc_q == PreMax) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PreWidth'(1);
            end
        end
    end

    // Seconds next state: cleared by inc_min, otherwise BCD increment mod 60 on advance.
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        if (inc_min) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
        end else if (time_adv) begin
            if (sec_ones_q == 4'd9) begin
                sec_ones_d = 4'd0;
                if (sec_tens_q == 4'd5) begin
                    sec_tens_d = 4'd0;
                end else begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end
            end else begin
                sec_ones_d = sec_ones_q + 4'd1;
            end
        end
    end

    // Minutes next state: BCD increment mod 60 from either inc_min or a seconds carry.
    always_comb begin
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        if (min_step) begin
            if (min_ones_q == 4'd9) begin
                min_ones_d = 4'd0;
                if (min_tens_q == 4'd5) begin
                    min_tens_d = 4'd0;
                end else begin
                    min_tens_d = min_tens_q + 4'd1;
                end
            end else begin
                min_ones_d = min_ones_q + 4'd1;
            end
        end
    end

    // Hours next state: BCD increment mod 24, wrapping 23 -> 00.
    always_comb begin
        hr_ones_d = hr_ones_q;
        hr_tens_d = hr_tens_q;
        if (hr_step) begin
            if ((hr_tens_q == 4'd2) && (hr_ones_q == 4'd3)) begin
                hr_ones_d = 4'd0;
                hr_tens_d = 4'd0;
            end else if (hr_ones_q == 4'd9) begin
                hr_ones_d = 4'd0;
                hr_tens_d = hr_tens_q + 4'd1;
            end else begin
                hr_ones_d = hr_ones_q + 4'd1;
            end
        end
    end

    // tick marks only timekeeping changes of the seconds, never set pulses.
    always_comb begin
        tick_d = time_adv;
    end

    // State registers with asynchronous clear to 00:00:00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            hr_ones_q  <= 4'd0;
            hr_tens_q  <= 4'd0;
            tick_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            hr_ones_q  <= hr_ones_d;
            hr_tens_q  <= hr_tens_d;
            tick_q     <= tick_d;
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign hr_ones  = hr_ones_q;
    assign hr_tens  = hr_tens_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter with a divide-by-4 prescaler.
// The reference model keeps hours/minutes/seconds as plain integers.
module tb_bcd_time_counter;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       inc_min;
    logic       inc_hour;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
    logic       tick;

    int checks;
    int failures;

    // Reference model state
    int mh, mm, ms, mp;
    logic mtick;

    bcd_time_counter #(
        .CLK_HZ (4),
        .TICK_HZ(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .inc_min (inc_min),
        .inc_hour(inc_hour),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .min_tens(min_tens),
        .hr_ones (hr_ones),
        .hr_tens (hr_tens),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] dut_time;
    assign dut_time = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

    function automatic logic [23:0] bcd24(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Model one rising edge from the clock-of-day rules.
    task automatic model_edge(input logic r, input logic im, input logic ih);
        logic adv;
        logic carry_h;
        int   t;
        adv     = r && (mp == 3);
        carry_h = 1'b0;
        if (im) begin
            mm = (mm + 1) % 60;
            ms = 0;
        end else if (adv) begin
            t = mm * 60 + ms + 1;
            if (t == 3600) carry_h = 1'b1;
            t  = t % 3600;
            mm = t / 60;
            ms = t % 60;
        end
        if (ih || carry_h) mh = (mh + 1) % 24;
        if (im) mp = 0;
        else if (r) mp = (mp + 1) % 4;
        mtick = adv && !im;
    endtask

    task automatic model_clear();
        mh = 0; mm = 0; ms = 0; mp = 0; mtick = 1'b0;
    endtask

    // Drive one cycle of inputs; returns 1 ns after the edge with pulses dropped.
    task automatic step(input logic r, input logic im, input logic ih);
        run      = r;
        inc_min  = im;
        inc_hour = ih;
        @(posedge clk);
        model_edge(r, im, ih);
        #1;
        inc_min  = 1'b0;
        inc_hour = 1'b0;
    endtask

    task automatic apply_reset();
        run      = 1'b0;
        inc_min  = 1'b0;
        inc_hour = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (dut_time !== 24'h0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: got %h tick %b want 000000 tick 0", dut_time, tick);
        end
        repeat (4) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (tick !== 1'b1 || dut_time !== 24'h000001) begin
            failures++;
            $display("FAIL reset_precount: got %h tick %b want 000001 tick 1", dut_time, tick);
        end
        // Assert reset mid-cycle, away from any edge.
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_time !== 24'h0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got %h tick %b want 000000 tick 0", dut_time, tick);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_time !== 24'h0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: got %h tick %b want 000000 tick 0", dut_time, tick);
        end
        #2;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_tick_timing();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (tick !== (i == 4) || sec_ones !== ((i == 4) ? 4'd1 : 4'd0)) begin
                failures++;
                $display("FAIL tick_first edge %0d: got tick %b sec_ones %0d want tick %b",
                         i, tick, sec_ones, (i == 4));
            end
        end
        repeat (36) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (tick !== 1'b1 || sec_tens !== 4'd1 || sec_ones !== 4'd0) begin
            failures++;
            $display("FAIL tick_ten: got tick %b sec %0d%0d want tick 1 sec 10",
                     tick, sec_tens, sec_ones);
        end
    endtask

    task automatic test_set_pulses();
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if ({hr_tens, hr_ones} !== 8'h14) begin
            failures++;
            $display("FAIL set_hour14: got %h want 14", {hr_tens, hr_ones});
        end
        repeat (11) step(1'b0, 1'b0, 1'b1);
        checks++;
        if ({hr_tens, hr_ones} !== 8'h01) begin
            failures++;
            $display("FAIL set_hour25: got %h want 01", {hr_tens, hr_ones});
        end
        repeat (11) step(1'b0, 1'b0, 1'b1);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        repeat (37 * 4) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_time !== 24'h125937) begin
            failures++;
            $display("FAIL set_preset: got %h want 125937", dut_time);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_time !== 24'h120000 || tick !== 1'b0) begin
            failures++;
            $display("FAIL set_min_wrap: got %h tick %b want 120000 tick 0", dut_time, tick);
        end
    endtask

    task automatic test_rollover();
        apply_reset();
        repeat (23) step(1'b0, 1'b0, 1'b1);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        repeat (59 * 4) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_time !== 24'h235959) begin
            failures++;
            $display("FAIL roll_preset: got %h want 235959", dut_time);
        end
        repeat (4) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_time !== 24'h000000 || tick !== 1'b1) begin
            failures++;
            $display("FAIL roll_midnight: got %h tick %b want 000000 tick 1", dut_time, tick);
        end
    endtask

    task automatic test_dual_pulse();
        apply_reset();
        repeat (23) step(1'b0, 1'b0, 1'b1);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (dut_time !== 24'h000000) begin
            failures++;
            $display("FAIL dual_pulse: got %h want 000000", dut_time);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (dut_time !== 24'h000100 || tick !== 1'b0) begin
            failures++;
            $display("FAIL collide_min: got %h tick %b want 000100 tick 0", dut_time, tick);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (tick !== (i == 4)) begin
                failures++;
                $display("FAIL collide_next edge %0d: got tick %b want %b", i, tick, (i == 4));
            end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (dut_time !== 24'h0 || tick !== 1'b0) begin
                failures++;
                $display("FAIL hold cycle %0d: got %h tick %b want 000000 tick 0",
                         i, dut_time, tick);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (tick !== 1'b0) begin
            failures++;
            $display("FAIL hold_resume1: got tick %b want 0", tick);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (tick !== 1'b1 || dut_time !== 24'h000001) begin
            failures++;
            $display("FAIL hold_resume2: got %h tick %b want 000001 tick 1", dut_time, tick);
        end
    endtask

    task automatic test_random();
        logic r, im, ih;
        logic [23:0] exp_time;
        apply_reset();
        for (int i = 0; i < 8000; i++) begin
            r  = ($urandom_range(0, 9) != 0);
            im = (i < 2000) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 399) == 0);
            ih = ($urandom_range(0, 14) == 0);
            step(r, im, ih);
            exp_time = bcd24(mh, mm, ms);
            checks++;
            if (dut_time !== exp_time || tick !== mtick) begin
                failures++;
                $display("FAIL random cycle %0d: got %h tick %b want %h tick %b",
                         i, dut_time, tick, exp_time, mtick);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        run      = 1'b0;
        inc_min  = 1'b0;
        inc_hour = 1'b0;
        model_clear();
        #2;
        test_reset();
        test_tick_timing();
        test_set_pulses();
        test_rollover();
        test_dual_pulse();
        test_collision();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
